// File: rtl/gtxe2_chnl_outclk_sel_ctrl_pkg.sv
// Shared definitions for the GTXE2 TXOUTCLK source-select controller and the outclk mux.
package gtxe2_chnl_outclk_sel_ctrl_pkg;

    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = 8;

    typedef logic [SEL_W-1:0] outclk_sel_t;

    localparam outclk_sel_t SEL_OFF     = 3'b000;
    localparam outclk_sel_t SEL_PCS     = 3'b001;
    localparam outclk_sel_t SEL_PMA     = 3'b010;
    localparam outclk_sel_t SEL_REFDIV1 = 3'b011;
    localparam outclk_sel_t SEL_REFDIV2 = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATE   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_FIN    = 2'd3
    } sel_state_t;

    // Only the four real clock sources may be requested; OFF is internal to the switch sequence.
    function automatic logic is_legal_sel(input outclk_sel_t sel);
        return (sel >= SEL_PCS) && (sel <= SEL_REFDIV2);
    endfunction

endpackage

// File: rtl/gtxe2_chnl_outclk_sel_ctrl.sv
// Glitch-safe TXOUTCLKSEL sequencer: parks the mux on OFF, applies the new source, waits to settle.
module gtxe2_chnl_outclk_sel_ctrl
    import gtxe2_chnl_outclk_sel_ctrl_pkg::*;
#(
    parameter int unsigned GATE_CYCLES   = 8,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter logic [2:0]  RESET_SEL     = 3'b011
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             REQ_VALID,
    input  logic [SEL_W-1:0] REQ_SEL,
    output logic             REQ_READY,
    output logic [SEL_W-1:0] TXOUTCLKSEL,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    sel_state_t        state;
    sel_state_t        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    outclk_sel_t       lat_sel;
    outclk_sel_t       lat_sel_nxt;
    outclk_sel_t       sel_nxt;
    logic              done_nxt;
    logic              err_nxt;

    // State, counter and all outputs are registered from the next-state decode.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            lat_sel     <= RESET_SEL;
            TXOUTCLKSEL <= RESET_SEL;
            DONE        <= 1'b0;
            ERR         <= 1'b0;
            REQ_READY   <= 1'b1;
            BUSY        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            lat_sel     <= lat_sel_nxt;
            TXOUTCLKSEL <= sel_nxt;
            DONE        <= done_nxt;
            ERR         <= err_nxt;
            REQ_READY   <= (state_nxt == ST_IDLE);
            BUSY        <= (state_nxt != ST_IDLE);
        end
    end

    // Next-state decode; the counter is loaded with (length-1) on entry and exits at zero.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        lat_sel_nxt = lat_sel;
        sel_nxt     = TXOUTCLKSEL;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    if (!is_legal_sel(REQ_SEL)) begin
                        err_nxt = 1'b1;
                    end else if (REQ_SEL == TXOUTCLKSEL) begin
                        state_nxt = ST_FIN;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt   = ST_GATE;
                        cnt_nxt     = GATE_LOAD;
                        lat_sel_nxt = REQ_SEL;
                        sel_nxt     = SEL_OFF;
                    end
                end
            end

            ST_GATE: begin
                if (cnt == '0) begin
                    state_nxt = ST_SETTLE;
                    cnt_nxt   = SETTLE_LOAD;
                    sel_nxt   = lat_sel;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end

            ST_SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = ST_FIN;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end

            ST_FIN: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end

            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_gtxe2_chnl_outclk_sel_ctrl.sv
// Directed scoreboard bench for the TXOUTCLKSEL switch sequencer.
module tb_gtxe2_chnl_outclk_sel_ctrl;

    localparam int KIND_DONE = 1;
    localparam int KIND_ERR  = 2;

    typedef struct {
        int         kind;
        int         latency;
        logic [2:0] sel;
        int         zeros;
        int         busy;
    } exp_t;

    logic       CLK;
    logic       RST_N;
    logic       REQ_VALID;
    logic [2:0] REQ_SEL;
    logic       REQ_READY;
    logic [2:0] TXOUTCLKSEL;
    logic       BUSY;
    logic       DONE;
    logic       ERR;

    int   vectors     = 0;
    int   miscompares = 0;
    int   violations  = 0;
    exp_t exp_q[$];

    logic       rst_at_edge = 1'b1;
    logic [2:0] prev_sel;

    gtxe2_chnl_outclk_sel_ctrl dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .REQ_VALID   (REQ_VALID),
        .REQ_SEL     (REQ_SEL),
        .REQ_READY   (REQ_READY),
        .TXOUTCLKSEL (TXOUTCLKSEL),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .ERR         (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Mux-safety monitor: no direct hop between two sources (reset excepted), no DONE with ERR.
    always @(posedge CLK) rst_at_edge <= !RST_N;
    always @(negedge CLK) begin
        if (!rst_at_edge && prev_sel != 3'b000 && TXOUTCLKSEL != 3'b000 && TXOUTCLKSEL != prev_sel)
            violations++;
        if (DONE === 1'b1 && ERR === 1'b1)
            violations++;
        prev_sel = TXOUTCLKSEL;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input int kind, input int latency, input logic [2:0] sel,
                            input int zeros, input int busy);
        exp_t e;
        e.kind    = kind;
        e.latency = latency;
        e.sel     = sel;
        e.zeros   = zeros;
        e.busy    = busy;
        exp_q.push_back(e);
    endtask

    // Raise a request and hold it until a rising edge sees REQ_READY; returns one sample after acceptance.
    task automatic drive(input logic [2:0] sel, input bit hold);
        bit accepted = 0;
        REQ_VALID = 1'b1;
        REQ_SEL   = sel;
        for (int i = 0; i < 200; i++) begin
            if (REQ_READY === 1'b1) begin
                step();
                accepted = 1;
                break;
            end
            step();
        end
        check("accept_seen", 32'(accepted), 32'd1);
        if (!hold) REQ_VALID = 1'b0;
    endtask

    // Wait for DONE or ERR, measuring latency from acceptance, then score against the queue head.
    task automatic wait_event(input string tag);
        int   lat   = 1;
        int   zeros = 0;
        int   busy  = 0;
        int   kind  = 0;
        bit   got   = 0;
        exp_t e;
        for (int i = 0; i < 200; i++) begin
            if (DONE === 1'b1 || ERR === 1'b1) begin
                got = 1;
                break;
            end
            if (TXOUTCLKSEL === 3'b000) zeros++;
            if (BUSY === 1'b1) busy++;
            step();
            lat++;
        end
        check({tag, "_event_seen"}, 32'(got), 32'd1);
        check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            kind = (DONE === 1'b1) ? KIND_DONE : ((ERR === 1'b1) ? KIND_ERR : 0);
            check({tag, "_kind"},    32'(kind),        32'(e.kind));
            check({tag, "_latency"}, 32'(lat),         32'(e.latency));
            check({tag, "_sel"},     32'(TXOUTCLKSEL), 32'(e.sel));
            check({tag, "_zeros"},   32'(zeros),       32'(e.zeros));
            check({tag, "_busy"},    32'(busy),        32'(e.busy));
        end
    endtask

    // Watch for a quiet period with no DONE and no ERR pulse.
    task automatic expect_quiet(input string tag, input int cycles);
        int dones = 0;
        int errs  = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (DONE === 1'b1) dones++;
            if (ERR === 1'b1) errs++;
        end
        check({tag, "_no_done"}, 32'(dones), 32'd0);
        check({tag, "_no_err"},  32'(errs),  32'd0);
    endtask

    initial begin
        RST_N     = 1'b0;
        REQ_VALID = 1'b0;
        REQ_SEL   = 3'b000;
        repeat (3) step();
        RST_N = 1'b1;

        check("rst_sel",   32'(TXOUTCLKSEL), 32'h3);
        check("rst_ready", 32'(REQ_READY),   32'h1);
        check("rst_busy",  32'(BUSY),        32'h0);
        check("rst_done",  32'(DONE),        32'h0);
        check("rst_err",   32'(ERR),         32'h0);

        // Same source as current: straight to FIN, no OFF phase.
        push_exp(KIND_DONE, 1, 3'b011, 0, 0);
        drive(3'b011, 0);
        wait_event("same_011");

        // Full switch 011 -> 010.
        push_exp(KIND_DONE, 25, 3'b010, 8, 24);
        drive(3'b010, 0);
        wait_event("sw_010");
        check("sw_010_busy_in_fin", 32'(BUSY), 32'h1);
        step();
        check("sw_010_ready_after", 32'(REQ_READY), 32'h1);

        // Illegal codes at both ends of the range and in the middle.
        push_exp(KIND_ERR, 1, 3'b010, 0, 0);
        drive(3'b110, 0);
        wait_event("ill_110");
        expect_quiet("ill_110", 30);
        check("ill_110_sel_kept", 32'(TXOUTCLKSEL), 32'h2);

        push_exp(KIND_ERR, 1, 3'b010, 0, 0);
        drive(3'b000, 0);
        wait_event("ill_000");

        push_exp(KIND_ERR, 1, 3'b010, 0, 0);
        drive(3'b101, 0);
        wait_event("ill_101");
        step();
        check("ill_err_one_cycle", 32'(ERR), 32'h0);

        // Second request held during a switch is ignored until IDLE, then accepted.
        push_exp(KIND_DONE, 25, 3'b100, 8, 24);
        drive(3'b100, 1);
        REQ_SEL = 3'b001;
        wait_event("held_first");
        push_exp(KIND_DONE, 25, 3'b001, 8, 24);
        drive(3'b001, 0);
        wait_event("held_second");
        check("held_final_sel", 32'(TXOUTCLKSEL), 32'h1);

        // Reset pulse in SETTLE aborts the switch without DONE.
        drive(3'b010, 0);
        repeat (11) step();
        check("abort_in_settle_sel", 32'(TXOUTCLKSEL), 32'h2);
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        check("abort_sel",   32'(TXOUTCLKSEL), 32'h3);
        check("abort_ready", 32'(REQ_READY),   32'h1);
        check("abort_busy",  32'(BUSY),        32'h0);
        expect_quiet("abort", 30);

        // Request in the very first cycle after reset release.
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        push_exp(KIND_DONE, 25, 3'b100, 8, 24);
        drive(3'b100, 0);
        wait_event("post_rst");

        repeat (3) step();
        check("sb_drained",   32'(exp_q.size()), 32'd0);
        check("mux_monitor",  32'(violations),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gtxe2_chnl_outclk_sel_ctrl.md
GTXE2_CHNL_OUTCLK_SEL_CTRL -- requirements
Module: gtxe2_chnl_outclk_sel_ctrl

Interface
REQ-001 Parameter GATE_CYCLES, default 8: cycles TXOUTCLKSEL is held at 3'b000 (output parked high) before a new source is applied; legal range 1..255.
REQ-002 Parameter SETTLE_CYCLES, default 16: cycles after applying a new source before completion is reported; legal range 1..255.
REQ-003 Parameter RESET_SEL, default 3'b011: TXOUTCLKSEL value after reset (TXPLLREFCLK_DIV1).
REQ-004 The block SHALL have one clock; reset is synchronous and active-low.
REQ-005 CLK  input  1  sole clock; all state changes on rising edge.
REQ-006 RST_N  input  1  synchronous active-low reset.
REQ-007 REQ_VALID  input  1  source-change request.
REQ-008 REQ_SEL  input  3  requested source code.
REQ-009 REQ_READY  output  1  request accepted when REQ_VALID and REQ_READY are both high.
REQ-010 TXOUTCLKSEL  output  3  select code driven to the TXOUTCLK mux.
REQ-011 BUSY  output  1  high while a switch is in progress.
REQ-012 DONE  output  1  one-cycle pulse on switch completion.
REQ-013 ERR  output  1  one-cycle pulse on rejected request.

Function
REQ-014 The FSM SHALL have the states IDLE, GATE, SETTLE and FIN.
REQ-015 REQ_READY SHALL equal (state==IDLE); BUSY SHALL equal (state!=IDLE).
REQ-016 Legal REQ_SEL codes are 3'b001..3'b100; on acceptance of 3'b000 or 3'b101..3'b111, ERR SHALL pulse the next cycle, the state SHALL stay IDLE and TXOUTCLKSEL SHALL be unchanged.
REQ-017 On acceptance of a legal REQ_SEL equal to the current TXOUTCLKSEL, the FSM SHALL go to FIN with no gating, and DONE SHALL pulse one cycle after acceptance.
REQ-018 On acceptance of a legal, differing REQ_SEL, REQ_SEL SHALL be latched, the FSM SHALL enter GATE and TXOUTCLKSEL SHALL be 3'b000 from the next cycle.
REQ-019 GATE SHALL last exactly GATE_CYCLES cycles; on exit, TXOUTCLKSEL SHALL take the latched code and the FSM SHALL enter SETTLE.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then the FSM SHALL enter FIN.
REQ-021 FIN SHALL last one cycle with DONE high, then the FSM SHALL return to IDLE. DONE therefore occurs GATE_CYCLES+SETTLE_CYCLES+1 cycles after the acceptance edge.
REQ-022 REQ_VALID while BUSY SHALL be ignored (no latch, no ERR); the requester SHALL hold REQ_VALID until it is accepted.
REQ-023 TXOUTCLKSEL SHALL never change directly between two non-zero codes; every source change SHALL pass through 3'b000 for at least GATE_CYCLES cycles.
REQ-024 TXOUTCLKSEL SHALL be registered, with no combinational path from inputs.
REQ-025 DONE and ERR SHALL never be high in the same cycle.
REQ-026 The shared cycle counter SHALL be 8 bits wide, load at each state entry, and never wrap.

Reset
REQ-027 While RST_N=0 at a clock edge: state=IDLE, TXOUTCLKSEL=RESET_SEL, DONE=0, ERR=0, counter=0, latched code=RESET_SEL.
REQ-028 Reset asserted mid-switch (GATE or SETTLE) SHALL abort the switch without a DONE pulse; TXOUTCLKSEL SHALL be RESET_SEL on the next cycle.
REQ-029 REQ_VALID in the first cycle after reset release SHALL be accepted normally.

Structure
REQ-030 The select-code constants (OFF=000, PCS=001, PMA=010, REFDIV1=011, REFDIV2=100) and the FSM state encoding SHALL live in a shared package used with the outclk mux.
REQ-031 The block SHALL be a single module with one FSM and one down-counter; there SHALL be no sub-modules.

Verification
REQ-032 Reset with defaults -> TXOUTCLKSEL=011, REQ_READY=1, BUSY=0, DONE=0, ERR=0.
REQ-033 Request REQ_SEL=010 from 011 -> TXOUTCLKSEL=000 for 8 cycles, then 010; DONE pulses exactly 25 cycles after acceptance; BUSY is high for 24 cycles.
REQ-034 Request REQ_SEL=011 while TXOUTCLKSEL=011 -> no 000 phase; DONE pulses 1 cycle after acceptance.
REQ-035 Request REQ_SEL=110 -> ERR pulses once, TXOUTCLKSEL is unchanged, no DONE.
REQ-036 Second REQ_VALID (001) held during a switch to 100 -> it is ignored until IDLE, then accepted; the final TXOUTCLKSEL is 001 with two DONE pulses. A monitor confirms there is never a direct non-zero-to-non-zero transition.
REQ-037 RST_N=0 for one cycle in SETTLE -> TXOUTCLKSEL=011 on the next cycle, and no DONE pulse for the aborted switch.
